// File: rtl/sar_approx_register.sv
// sar_approx_register
//   Successive-approximation control stage. On a Start request it runs a
//   sample window, then resolves one result bit per step (MSB first) from the
//   external comparator and presents the trial/final code to the downstream
//   SAR timer stage. After a conversion the result is held in IDLE or TRACK.
//
// Parameters
//   WIDTH          result width in bits (2..16)
//   SAMPLE_CYCLES  cycles spent in SAMPLE before the first trial (0 acts as 1)
//
// Ports
//   ClockT    in   single clock, rising edge
//   ResetN    in   asynchronous active-low reset
//   Start     in   conversion request, honoured only in IDLE or TRACK
//   CompIn    in   comparator: 1 = analog input >= DAC(SAROut)
//   TrackEn   in   1 = go to TRACK after a conversion instead of IDLE
//   SAROut    out  trial code during CONVERT, final result otherwise
//   StateP    out  00 IDLE, 01 SAMPLE, 10 CONVERT, 11 TRACK
//   Busy      out  high in SAMPLE or CONVERT
//   EOC       out  one-cycle pulse, first cycle SAROut holds the final result
//   SampleEn  out  sample switch enable, high only in SAMPLE
//
// Build option
//   SAR_SETTLE_EN  when defined, CompIn goes through a 2-flop synchronizer and
//                  every CONVERT step lasts 3 cycles; the decision is taken on
//                  the 3rd cycle from the synchronized comparator value.

module sar_approx_register #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SAMPLE_CYCLES = 4
) (
  input  logic             ClockT,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             CompIn,
  input  logic             TrackEn,
  output logic [WIDTH-1:0] SAROut,
  output logic [1:0]       StateP,
  output logic             Busy,
  output logic             EOC,
  output logic             SampleEn
);

  localparam int unsigned StepW = $clog2(WIDTH) + 1;

  // A zero sample window would never leave SAMPLE, so it is promoted to one.
  localparam logic [7:0] SampLoad = (SAMPLE_CYCLES == 0) ? 8'd1 : 8'(SAMPLE_CYCLES);

  localparam logic [StepW-1:0] LastStep = StepW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MsbMask  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StSample  = 2'b01,
    StConvert = 2'b10,
    StTrack   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sar_q, sar_d;
  logic             eoc_q, eoc_d;
  logic [7:0]       samp_cnt_q, samp_cnt_d;
  logic [StepW-1:0] step_q, step_d;

  logic             comp_bit;   // comparator value used for the decision
  logic             decide;     // this cycle ends a CONVERT step
  logic [WIDTH-1:0] trial_mask; // bit currently under trial
  logic [WIDTH-1:0] next_mask;  // bit to be tried next (zero after bit 0)

`ifdef SAR_SETTLE_EN
  // Comparator may be asynchronous to ClockT in this build.
  logic [1:0] sync_q;
  logic [1:0] sub_q, sub_d;

  always_ff @(posedge ClockT or negedge ResetN) begin
    if (!ResetN) begin
      sync_q <= 2'b00;
      sub_q  <= 2'd0;
    end else begin
      sync_q <= {sync_q[0], CompIn};
      sub_q  <= sub_d;
    end
  end

  // Sub-cycle counter within a step: 0,1 settle, 2 decide.
  always_comb begin
    sub_d = 2'd0;
    if (state_q == StConvert && !decide) begin
      sub_d = sub_q + 2'd1;
    end
  end

  assign comp_bit = sync_q[1];
  assign decide   = (sub_q == 2'd2);
`else
  assign comp_bit = CompIn;
  assign decide   = 1'b1;
`endif

  assign trial_mask = MsbMask >> step_q;
  assign next_mask  = trial_mask >> 1;

  always_comb begin
    state_d    = state_q;
    sar_d      = sar_q;
    eoc_d      = 1'b0;
    samp_cnt_d = samp_cnt_q;
    step_d     = step_q;

    case (state_q)
      StIdle: begin
        if (Start) begin
          state_d    = StSample;
          samp_cnt_d = SampLoad;
        end
      end

      StSample: begin
        if (samp_cnt_q <= 8'd1) begin
          state_d    = StConvert;
          sar_d      = MsbMask;
          step_d     = '0;
          samp_cnt_d = 8'd0;
        end else begin
          samp_cnt_d = samp_cnt_q - 8'd1;
        end
      end

      StConvert: begin
        if (decide) begin
          // Keep or clear the trial bit, and raise the next one in the same edge.
          sar_d = (comp_bit ? sar_q : (sar_q & ~trial_mask)) | next_mask;
          if (step_q == LastStep) begin
            state_d = TrackEn ? StTrack : StIdle;
            eoc_d   = 1'b1;
            step_d  = '0;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
      end

      StTrack: begin
        // Start wins over leaving TRACK.
        if (Start) begin
          state_d    = StSample;
          samp_cnt_d = SampLoad;
        end else if (!TrackEn) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ClockT or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= StIdle;
      sar_q      <= '0;
      eoc_q      <= 1'b0;
      samp_cnt_q <= 8'd0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      sar_q      <= sar_d;
      eoc_q      <= eoc_d;
      samp_cnt_q <= samp_cnt_d;
      step_q     <= step_d;
    end
  end

  assign SAROut   = sar_q;
  assign StateP   = state_q;
  assign EOC      = eoc_q;
  assign Busy     = (state_q == StSample) || (state_q == StConvert);
  assign SampleEn = (state_q == StSample);

endmodule

// File: tb/tb_sar_approx_register.sv
// Directed bench for sar_approx_register with an ideal comparator model
// (CompIn = Vin >= SAROut) and default parameters.

module tb_sar_approx_register;

`ifdef SAR_SETTLE_EN
  localparam int Lat = 4 + 3 * 8 + 1;
`else
  localparam int Lat = 4 + 8 + 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       comp_in;
  logic       track_en;
  logic [7:0] sar_out;
  logic [1:0] state_p;
  logic       busy;
  logic       eoc;
  logic       sample_en;
  logic [7:0] vin;

  int n_checks;
  int n_pass;
  int eoc_cnt;

  sar_approx_register #(
    .WIDTH        (8),
    .SAMPLE_CYCLES(4)
  ) u_dut (
    .ClockT  (clk),
    .ResetN  (rst_n),
    .Start   (start),
    .CompIn  (comp_in),
    .TrackEn (track_en),
    .SAROut  (sar_out),
    .StateP  (state_p),
    .Busy    (busy),
    .EOC     (eoc),
    .SampleEn(sample_en)
  );

  assign comp_in = (vin >= sar_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock edge, outputs sampled 1 time unit later; counts EOC pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (eoc) eoc_cnt++;
  endtask

  // Start a conversion; lat counts edges with the Start-sampling edge as 1.
  // inject >= 0 raises Start again for one cycle at that count.
  task automatic run_conv(input logic [7:0] v, input logic trk, input int inject,
                          output int lat);
    vin      = v;
    track_en = trk;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!eoc && lat < 200) begin
      start = (lat == inject);
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  int         lat;
  int         n_trial;
  logic [7:0] trials[8];
  logic [7:0] prev;
  int         e1, e2, cyc;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    eoc_cnt  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    track_en = 1'b0;
    vin      = 8'h00;

    // Reset state
    #12;
    check("rst_state", 32'(state_p), 32'h0);
    check("rst_sar", 32'(sar_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_eoc", 32'(eoc), 32'h0);
    check("rst_sample_en", 32'(sample_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic conversion, Vin = 0xA5, with SAMPLE/CONVERT decode checks
    vin      = 8'hA5;
    track_en = 1'b0;
    eoc_cnt  = 0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("a5_sample_state", 32'(state_p), 32'h1);
    check("a5_sample_en", 32'(sample_en), 32'h1);
    check("a5_sample_busy", 32'(busy), 32'h1);
    lat = 1;
    while (!eoc && lat < 200) begin
      tick();
      lat++;
      if (lat == 6) begin
        check("a5_conv_state", 32'(state_p), 32'h2);
        check("a5_conv_sample_en", 32'(sample_en), 32'h0);
        check("a5_conv_busy", 32'(busy), 32'h1);
      end
    end
    check("a5_latency", 32'(lat), 32'(Lat));
    check("a5_result", 32'(sar_out), 32'hA5);
    check("a5_state_idle", 32'(state_p), 32'h0);
    check("a5_busy_low", 32'(busy), 32'h0);
    tick();
    check("a5_eoc_one_cycle", 32'(eoc), 32'h0);
    check("a5_result_held", 32'(sar_out), 32'hA5);
    tick();
    check("a5_eoc_count", 32'(eoc_cnt), 32'd1);

    // All-ones and all-zeros bounds
    eoc_cnt = 0;
    run_conv(8'hFF, 1'b0, -1, lat);
    check("ff_result", 32'(sar_out), 32'hFF);
    check("ff_latency", 32'(lat), 32'(Lat));
    tick();
    tick();
    check("ff_eoc_count", 32'(eoc_cnt), 32'd1);

    eoc_cnt = 0;
    run_conv(8'h00, 1'b0, -1, lat);
    check("00_result", 32'(sar_out), 32'h00);
    check("00_latency", 32'(lat), 32'(Lat));
    tick();
    tick();
    check("00_eoc_count", 32'(eoc_cnt), 32'd1);

    // Trial sequence for Vin = 0x80
    vin     = 8'h80;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    n_trial = 0;
    prev    = 8'h00;
    cyc     = 0;
    while (!eoc && cyc < 200) begin
      tick();
      cyc++;
      if (state_p == 2'b10 && n_trial < 8 && (n_trial == 0 || sar_out != prev)) begin
        trials[n_trial] = sar_out;
        prev            = sar_out;
        n_trial++;
      end
    end
    check("t80_ntrials", 32'(n_trial), 32'd8);
    check("t80_trial0", 32'(trials[0]), 32'h80);
    check("t80_trial1", 32'(trials[1]), 32'hC0);
    check("t80_trial2", 32'(trials[2]), 32'hA0);
    check("t80_trial3", 32'(trials[3]), 32'h90);
    check("t80_trial4", 32'(trials[4]), 32'h88);
    check("t80_trial5", 32'(trials[5]), 32'h84);
    check("t80_trial6", 32'(trials[6]), 32'h82);
    check("t80_trial7", 32'(trials[7]), 32'h81);
    check("t80_final", 32'(sar_out), 32'h80);
    tick();

    // TRACK entry, hold, and exit on TrackEn=0
    run_conv(8'h3C, 1'b1, -1, lat);
    check("trk_latency", 32'(lat), 32'(Lat));
    check("trk_state", 32'(state_p), 32'h3);
    check("trk_result", 32'(sar_out), 32'h3C);
    tick();
    tick();
    check("trk_state_held", 32'(state_p), 32'h3);
    check("trk_result_held", 32'(sar_out), 32'h3C);
    check("trk_busy", 32'(busy), 32'h0);
    track_en = 1'b0;
    tick();
    check("trk_exit_idle", 32'(state_p), 32'h0);
    check("trk_exit_result", 32'(sar_out), 32'h3C);

    // Start in TRACK beats TrackEn=0
    run_conv(8'h3C, 1'b1, -1, lat);
    check("trk2_state", 32'(state_p), 32'h3);
    track_en = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("trk2_restart", 32'(state_p), 32'h1);
    lat = 1;
    while (!eoc && lat < 200) begin
      tick();
      lat++;
    end
    check("trk2_latency", 32'(lat), 32'(Lat));
    check("trk2_result", 32'(sar_out), 32'h3C);
    tick();

    // Start pulsed at CONVERT step 3 is ignored
    eoc_cnt = 0;
    run_conv(8'h5A, 1'b0, 8, lat);
    check("ign_latency", 32'(lat), 32'(Lat));
    check("ign_result", 32'(sar_out), 32'h5A);
    tick();
    check("ign_state_idle", 32'(state_p), 32'h0);
    tick();
    check("ign_eoc_count", 32'(eoc_cnt), 32'd1);

    // Start held high: back-to-back conversions
    vin      = 8'h77;
    track_en = 1'b0;
    start    = 1'b1;
    e1       = -1;
    e2       = -1;
    cyc      = 0;
    while (e2 < 0 && cyc < 200) begin
      tick();
      cyc++;
      if (eoc) begin
        if (e1 < 0) begin
          e1 = cyc;
          check("b2b_result1", 32'(sar_out), 32'h77);
          check("b2b_eoc_state", 32'(state_p), 32'h0);
        end else begin
          e2 = cyc;
          check("b2b_result2", 32'(sar_out), 32'h77);
        end
      end else if (e1 > 0 && cyc == e1 + 1) begin
        check("b2b_resample", 32'(state_p), 32'h1);
      end
    end
    check("b2b_first", 32'(e1), 32'(Lat));
    check("b2b_period", 32'(e2 - e1), 32'(Lat));
    start = 1'b0;
    cyc   = 0;
    while ((busy || eoc) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("b2b_drained", 32'(busy), 32'h0);
    tick();

    // Reset at CONVERT step 4 aborts asynchronously, no EOC
    eoc_cnt = 0;
    vin     = 8'h5A;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 9; i++) tick();
    check("rst_mid_in_convert", 32'(state_p), 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sar", 32'(sar_out), 32'h0);
    check("rst_mid_state", 32'(state_p), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_mid_no_eoc", 32'(eoc_cnt), 32'd0);
    check("rst_mid_idle", 32'(state_p), 32'h0);

    // Fresh conversion after reset release
    run_conv(8'h33, 1'b0, -1, lat);
    check("post_rst_latency", 32'(lat), 32'(Lat));
    check("post_rst_result", 32'(sar_out), 32'h33);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
